// File: rtl/serial_negate_rx.sv
// Serial two's-complement negator/deserializer, LSB first, one word per WIDTH accepted bits.
// Optional raw undecoded word output is enabled by defining SERIAL_NEGATE_RX_RAW_EN.
module serial_negate_rx #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic             t_clock,
  input  logic             r,
  input  logic             x,
  input  logic             bit_valid,
  output logic             y,
  output logic [WIDTH-1:0] word,
  output logic             word_valid,
  output logic             ovf,
`ifdef SERIAL_NEGATE_RX_RAW_EN
  output logic [WIDTH-1:0] raw,
`endif
  output logic [CW-1:0]    bit_cnt
);

  typedef enum logic {
    PASS = 1'b0,
    INV  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] MOST_NEG =
    {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [WIDTH-2:0] sh;
  logic [WIDTH-1:0] next_sh;
  logic             last;

  assign y       = x ^ (state == INV);
  assign next_sh = {y, sh};
  assign last    = (bit_cnt == CW'(WIDTH-1));

`ifdef SERIAL_NEGATE_RX_RAW_EN
  logic [WIDTH-2:0] raw_sh;
  logic [WIDTH-1:0] next_raw;

  assign next_raw = {x, raw_sh};

  always_ff @(posedge t_clock) begin
    if (r) begin
      raw_sh <= '0;
      raw    <= '0;
    end else if (bit_valid) begin
      if (last) begin
        raw_sh <= '0;
        raw    <= next_raw;
      end else begin
        raw_sh <= next_raw[WIDTH-1:1];
      end
    end
  end
`endif

  always_ff @(posedge t_clock) begin
    if (r) begin
      state      <= PASS;
      bit_cnt    <= '0;
      sh         <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (bit_valid) begin
        if (last) begin
          // word boundary: publish and restart decoding in PASS
          state      <= PASS;
          bit_cnt    <= '0;
          sh         <= '0;
          word       <= next_sh;
          ovf        <= (next_sh == MOST_NEG);
          word_valid <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
          sh      <= next_sh[WIDTH-1:1];
          unique case (state)
            PASS:    state <= x ? INV : PASS;
            INV:     state <= INV;
            default: state <= PASS;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_negate_rx.sv
// Directed bench for serial_negate_rx at WIDTH=8.
module tb_serial_negate_rx;

  logic       t_clock = 1'b0;
  logic       r;
  logic       x;
  logic       bit_valid;
  logic       y;
  logic [7:0] word;
  logic       word_valid;
  logic       ovf;
  logic [2:0] bit_cnt;
`ifdef SERIAL_NEGATE_RX_RAW_EN
  logic [7:0] raw;
  logic [7:0] rq[$];
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lc0, lc1;

  logic [7:0] wq[$];
  logic       oq[$];
  int         cq[$];

  serial_negate_rx #(.WIDTH(8)) dut (
    .t_clock    (t_clock),
    .r          (r),
    .x          (x),
    .bit_valid  (bit_valid),
    .y          (y),
    .word       (word),
    .word_valid (word_valid),
    .ovf        (ovf),
`ifdef SERIAL_NEGATE_RX_RAW_EN
    .raw        (raw),
`endif
    .bit_cnt    (bit_cnt)
  );

  always #5 t_clock = ~t_clock;

  always @(posedge t_clock) cyc <= cyc + 1;

  // record every cycle where word_valid is seen high
  always @(negedge t_clock) begin
    if (word_valid === 1'b1) begin
      wq.push_back(word);
      oq.push_back(ovf);
      cq.push_back(cyc);
`ifdef SERIAL_NEGATE_RX_RAW_EN
      rq.push_back(raw);
`endif
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    wq.delete();
    oq.delete();
    cq.delete();
`ifdef SERIAL_NEGATE_RX_RAW_EN
    rq.delete();
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge t_clock);
      bit_valid = 1'b0;
      x         = 1'b0;
    end
  endtask

  task automatic send_word(input logic [7:0] v,
                           input bit gap,
                           output int lc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (gap) begin
        @(negedge t_clock);
        bit_valid = 1'b0;
        x         = ~v[i];
        #1;
        check("gap_cnt", 32'(bit_cnt), i);
        check("gap_y", 32'(y), 32'(x ^ seen));
      end
      @(negedge t_clock);
      bit_valid = 1'b1;
      x         = v[i];
      #1;
      check("bit_cnt", 32'(bit_cnt), i);
      check("y", 32'(y), 32'(v[i] ^ seen));
      seen = seen | v[i];
    end
    lc = cyc;
  endtask

  initial begin
    r         = 1'b1;
    x         = 1'b0;
    bit_valid = 1'b0;
    repeat (2) @(negedge t_clock);
    #1;
    check("rst_word", 32'(word), 32'h00);
    check("rst_wv", 32'(word_valid), 32'h0);
    check("rst_ovf", 32'(ovf), 32'h0);
    check("rst_cnt", 32'(bit_cnt), 32'h0);
`ifdef SERIAL_NEGATE_RX_RAW_EN
    check("rst_raw", 32'(raw), 32'h00);
`endif
    @(negedge t_clock);
    r = 1'b0;
    x = 1'b1;
    #1;
    check("pass_y", 32'(y), 32'h1);
    idle(2);

    // 0x06 -> 0xFA, one-cycle latency
    clear_q();
    send_word(8'h06, 1'b0, lc0);
    idle(3);
    check("w06_cnt", wq.size(), 1);
    if (wq.size() >= 1) begin
      check("w06_word", 32'(wq[0]), 32'hFA);
      check("w06_ovf", 32'(oq[0]), 32'h0);
      check("w06_lat", cq[0], lc0 + 1);
`ifdef SERIAL_NEGATE_RX_RAW_EN
      check("w06_raw", 32'(rq[0]), 32'h06);
`endif
    end

    // back-to-back 0x00, 0x01
    clear_q();
    send_word(8'h00, 1'b0, lc0);
    send_word(8'h01, 1'b0, lc1);
    idle(3);
    check("b2b_cnt", wq.size(), 2);
    if (wq.size() >= 2) begin
      check("b2b_w0", 32'(wq[0]), 32'h00);
      check("b2b_w1", 32'(wq[1]), 32'hFF);
      check("b2b_gap", cq[1] - cq[0], 8);
    end

    // most-negative then 0x06
    clear_q();
    send_word(8'h80, 1'b0, lc0);
    idle(2);
    check("neg_hold_w", 32'(word), 32'h80);
    check("neg_hold_o", 32'(ovf), 32'h1);
    send_word(8'h06, 1'b0, lc1);
    idle(3);
    check("neg_cnt", wq.size(), 2);
    if (wq.size() >= 2) begin
      check("neg_w0", 32'(wq[0]), 32'h80);
      check("neg_o0", 32'(oq[0]), 32'h1);
      check("neg_w1", 32'(wq[1]), 32'hFA);
      check("neg_o1", 32'(oq[1]), 32'h0);
    end
    check("neg_hold_o2", 32'(ovf), 32'h0);

    // reset mid-word, reset beats bit_valid
    clear_q();
    begin
      logic [7:0] v;
      v = 8'h06;
      for (int i = 0; i < 3; i++) begin
        @(negedge t_clock);
        bit_valid = 1'b1;
        x         = v[i];
      end
    end
    @(negedge t_clock);
    r         = 1'b1;
    bit_valid = 1'b1;
    x         = 1'b1;
    @(negedge t_clock);
    r         = 1'b0;
    bit_valid = 1'b0;
    x         = 1'b0;
    #1;
    check("mid_cnt", 32'(bit_cnt), 32'h0);
    check("mid_word", 32'(word), 32'h00);
    check("mid_ovf", 32'(ovf), 32'h0);
    send_word(8'h06, 1'b0, lc0);
    idle(3);
    check("mid_pulses", wq.size(), 1);
    if (wq.size() >= 1)
      check("mid_w", 32'(wq[0]), 32'hFA);

    // gapped 0x06
    clear_q();
    send_word(8'h06, 1'b1, lc0);
    idle(3);
    check("gap_pulses", wq.size(), 1);
    if (wq.size() >= 1) begin
      check("gap_w", 32'(wq[0]), 32'hFA);
      check("gap_lat", cq[0], lc0 + 1);
`ifdef SERIAL_NEGATE_RX_RAW_EN
      check("gap_raw", 32'(rq[0]), 32'h06);
`endif
    end
    check("gap_hold_w", 32'(word), 32'hFA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
